// File: rtl/spm_uram_banked.sv
// Banked true-dual-port scratchpad with byte enables, read pipeline and optional zero-fill after reset.
// Define SPM_WR_FWD_EN to return the post-write word on a read/write same-address collision.
module spm_uram_banked #(
  parameter int unsigned DEPTH      = 16384,
  parameter int unsigned ADDR_WIDTH = 14,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned NB_BANK    = 4,
  parameter int unsigned NB_PIPE    = 3,
  parameter int unsigned INIT_CLR   = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  output logic                    o_ready,
  input  logic [ADDR_WIDTH-1:0]   i_addr_a,
  input  logic                    i_en_a,
  input  logic                    i_wr_en_a,
  input  logic [DATA_WIDTH/8-1:0] i_be_a,
  input  logic [DATA_WIDTH-1:0]   i_wr_data_a,
  output logic [DATA_WIDTH-1:0]   o_rd_data_a,
  output logic                    o_rd_vld_a,
  input  logic [ADDR_WIDTH-1:0]   i_addr_b,
  input  logic                    i_en_b,
  input  logic                    i_wr_en_b,
  input  logic [DATA_WIDTH/8-1:0] i_be_b,
  input  logic [DATA_WIDTH-1:0]   i_wr_data_b,
  output logic [DATA_WIDTH-1:0]   o_rd_data_b,
  output logic                    o_rd_vld_b,
  output logic                    o_collision
);

  localparam int unsigned NBE    = DATA_WIDTH / 8;
  localparam int unsigned LOG_NB = $clog2(NB_BANK);
  localparam int unsigned BW     = (LOG_NB > 0) ? LOG_NB : 1;
  localparam int unsigned ROWS   = DEPTH / NB_BANK;
  localparam int unsigned RW     = (ADDR_WIDTH > LOG_NB) ? ADDR_WIDTH - LOG_NB : 1;
  localparam logic [ADDR_WIDTH-1:0] BANK_MASK = ADDR_WIDTH'(NB_BANK - 1);

  typedef enum logic {INIT, RUN} state_e;

  state_e                state_q, state_d;
  logic [RW-1:0]         row_cnt_q, row_cnt_d;
  logic                  ready_q, ready_d;
  logic                  coll_q, coll_d;

  logic [DATA_WIDTH-1:0] mem [NB_BANK][ROWS];

  logic                  acc_a, acc_b, wr_a, wr_b, rd_a, rd_b, same_addr;
  logic [BW-1:0]         bank_a, bank_b;
  logic [RW-1:0]         row_a, row_b;
  logic [DATA_WIDTH-1:0] rd_word_a, rd_word_b;

  logic [NB_PIPE-1:0]    vld_a_q, vld_a_d, vld_b_q, vld_b_d;
  logic [DATA_WIDTH-1:0] dat_a_q [NB_PIPE];
  logic [DATA_WIDTH-1:0] dat_a_d [NB_PIPE];
  logic [DATA_WIDTH-1:0] dat_b_q [NB_PIPE];
  logic [DATA_WIDTH-1:0] dat_b_d [NB_PIPE];

  always_comb begin
    acc_a     = i_en_a & ready_q;
    acc_b     = i_en_b & ready_q;
    wr_a      = acc_a & i_wr_en_a;
    wr_b      = acc_b & i_wr_en_b;
    rd_a      = acc_a & ~i_wr_en_a;
    rd_b      = acc_b & ~i_wr_en_b;
    bank_a    = BW'(i_addr_a & BANK_MASK);
    bank_b    = BW'(i_addr_b & BANK_MASK);
    row_a     = RW'(i_addr_a >> LOG_NB);
    row_b     = RW'(i_addr_b >> LOG_NB);
    same_addr = (i_addr_a == i_addr_b);
    coll_d    = acc_a & acc_b & same_addr & (i_wr_en_a | i_wr_en_b);
    // Array read happens before this edge's writes land, which gives read-first by default.
    rd_word_a = mem[bank_a][row_a];
    rd_word_b = mem[bank_b][row_b];
`ifdef SPM_WR_FWD_EN
    for (int unsigned k = 0; k < NBE; k++) begin
      if (rd_a && wr_b && same_addr && i_be_b[k]) rd_word_a[k*8 +: 8] = i_wr_data_b[k*8 +: 8];
      if (rd_b && wr_a && same_addr && i_be_a[k]) rd_word_b[k*8 +: 8] = i_wr_data_a[k*8 +: 8];
    end
`endif
  end

  always_comb begin
    state_d   = state_q;
    row_cnt_d = row_cnt_q;
    if (state_q == INIT) begin
      row_cnt_d = row_cnt_q + 1'b1;
      if (row_cnt_q == RW'(ROWS - 1)) begin
        state_d   = RUN;
        row_cnt_d = '0;
      end
    end
    ready_d = (state_d == RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= (INIT_CLR != 0) ? INIT : RUN;
      row_cnt_q <= '0;
      ready_q   <= 1'b0;
      coll_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      row_cnt_q <= row_cnt_d;
      ready_q   <= ready_d;
      coll_q    <= coll_d;
    end
  end

  // B bytes are written first so that A wins on bytes both ports enable.
  always_ff @(posedge clk) begin
    if (state_q == INIT) begin
      for (int unsigned b = 0; b < NB_BANK; b++) mem[b][row_cnt_q] <= '0;
    end else begin
      for (int unsigned k = 0; k < NBE; k++)
        if (wr_b && i_be_b[k]) mem[bank_b][row_b][k*8 +: 8] <= i_wr_data_b[k*8 +: 8];
      for (int unsigned k = 0; k < NBE; k++)
        if (wr_a && i_be_a[k]) mem[bank_a][row_a][k*8 +: 8] <= i_wr_data_a[k*8 +: 8];
    end
  end

  // The last pipeline stage doubles as the output register and only loads on valid.
  always_comb begin
    vld_a_d[0] = rd_a;
    vld_b_d[0] = rd_b;
    dat_a_d[0] = rd_word_a;
    dat_b_d[0] = rd_word_b;
    for (int unsigned i = 1; i < NB_PIPE; i++) begin
      vld_a_d[i] = vld_a_q[i-1];
      vld_b_d[i] = vld_b_q[i-1];
      dat_a_d[i] = dat_a_q[i-1];
      dat_b_d[i] = dat_b_q[i-1];
    end
    if (!vld_a_d[NB_PIPE-1]) dat_a_d[NB_PIPE-1] = dat_a_q[NB_PIPE-1];
    if (!vld_b_d[NB_PIPE-1]) dat_b_d[NB_PIPE-1] = dat_b_q[NB_PIPE-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_a_q <= '0;
      vld_b_q <= '0;
      for (int unsigned i = 0; i < NB_PIPE; i++) begin
        dat_a_q[i] <= '0;
        dat_b_q[i] <= '0;
      end
    end else begin
      vld_a_q <= vld_a_d;
      vld_b_q <= vld_b_d;
      for (int unsigned i = 0; i < NB_PIPE; i++) begin
        dat_a_q[i] <= dat_a_d[i];
        dat_b_q[i] <= dat_b_d[i];
      end
    end
  end

  assign o_ready     = ready_q;
  assign o_collision = coll_q;
  assign o_rd_vld_a  = vld_a_q[NB_PIPE-1];
  assign o_rd_vld_b  = vld_b_q[NB_PIPE-1];
  assign o_rd_data_a = dat_a_q[NB_PIPE-1];
  assign o_rd_data_b = dat_b_q[NB_PIPE-1];

endmodule

// File: tb/tb_spm_uram_banked.sv
// Self-checking bench for spm_uram_banked: directed scenarios plus random dual-port traffic
// against a word-array reference model with a per-cycle expected read schedule.
module tb_spm_uram_banked;

  localparam int unsigned NB_PIPE     = 3;
  localparam int unsigned INIT_CYCLES = 4096;
`ifdef SPM_WR_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        o_ready, o_collision;
  logic [13:0] addr_a, addr_b;
  logic        en_a, en_b, we_a, we_b;
  logic [7:0]  be_a, be_b;
  logic [63:0] wd_a, wd_b;
  logic [63:0] o_rd_data_a, o_rd_data_b;
  logic        o_rd_vld_a, o_rd_vld_b;

  always #5 clk = ~clk;

  spm_uram_banked #(
    .DEPTH(16384), .ADDR_WIDTH(14), .DATA_WIDTH(64),
    .NB_BANK(4), .NB_PIPE(NB_PIPE), .INIT_CLR(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .o_ready(o_ready),
    .i_addr_a(addr_a), .i_en_a(en_a), .i_wr_en_a(we_a), .i_be_a(be_a),
    .i_wr_data_a(wd_a), .o_rd_data_a(o_rd_data_a), .o_rd_vld_a(o_rd_vld_a),
    .i_addr_b(addr_b), .i_en_b(en_b), .i_wr_en_b(we_b), .i_be_b(be_b),
    .i_wr_data_b(wd_b), .o_rd_data_b(o_rd_data_b), .o_rd_vld_b(o_rd_vld_b),
    .o_collision(o_collision)
  );

  int unsigned pass_cnt = 0;
  int unsigned fail_cnt = 0;
  int          cyc = 0;
  logic [63:0] ref_mem [16384];
  logic [63:0] exp_a [int];
  logic [63:0] exp_b [int];
  logic [63:0] held_a, held_b;
  logic        exp_coll, run_m;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    assert (got === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] wd,
                                        input logic [7:0] be);
    logic [63:0] m;
    m = '0;
    for (int k = 0; k < 8; k++) m[k*8 +: 8] = {8{be[k]}};
    return (old & ~m) | (wd & m);
  endfunction

  task automatic sample();
    logic va, vb;
    va = exp_a.exists(cyc);
    vb = exp_b.exists(cyc);
    if (va) begin held_a = exp_a[cyc]; exp_a.delete(cyc); end
    if (vb) begin held_b = exp_b[cyc]; exp_b.delete(cyc); end
    chk("rd_vld_a", o_rd_vld_a, va);
    chk("rd_data_a", o_rd_data_a, held_a);
    chk("rd_vld_b", o_rd_vld_b, vb);
    chk("rd_data_b", o_rd_data_b, held_b);
    chk("collision", o_collision, exp_coll);
    chk("ready", o_ready, run_m);
  endtask

  // Called at a negedge with inputs already driven; models the next rising edge.
  task automatic step();
    logic acc_a, acc_b;
    logic [63:0] pre_a, pre_b;
    acc_a = en_a && run_m;
    acc_b = en_b && run_m;
    pre_a = ref_mem[addr_a];
    pre_b = ref_mem[addr_b];
    if (acc_b && we_b) ref_mem[addr_b] = merge(ref_mem[addr_b], wd_b, be_b);
    if (acc_a && we_a) ref_mem[addr_a] = merge(ref_mem[addr_a], wd_a, be_a);
    if (acc_a && !we_a) exp_a[cyc + NB_PIPE] = FWD ? ref_mem[addr_a] : pre_a;
    if (acc_b && !we_b) exp_b[cyc + NB_PIPE] = FWD ? ref_mem[addr_b] : pre_b;
    exp_coll = acc_a && acc_b && (addr_a == addr_b) && (we_a || we_b);
    @(posedge clk);
    cyc++;
    @(negedge clk);
    sample();
  endtask

  task automatic idle(input int n);
    en_a = 1'b0;
    en_b = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic reset_and_init();
    int   n;
    logic seen;
    en_a  = 1'b0;
    en_b  = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_vld_a", o_rd_vld_a, 0);
    chk("rst_vld_b", o_rd_vld_b, 0);
    chk("rst_data_a", o_rd_data_a, 0);
    chk("rst_data_b", o_rd_data_b, 0);
    chk("rst_collision", o_collision, 0);
    chk("rst_ready", o_ready, 0);
    exp_a.delete();
    exp_b.delete();
    held_a   = '0;
    held_b   = '0;
    exp_coll = 1'b0;
    run_m    = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    n     = 0;
    seen  = 1'b0;
    while (!o_ready && n < int'(INIT_CYCLES) + 100) begin
      @(negedge clk);
      n++;
      cyc++;
      if (o_rd_vld_a || o_rd_vld_b || o_collision) seen = 1'b1;
    end
    chk("init_cycles", n, INIT_CYCLES);
    chk("init_quiet", seen, 0);
    foreach (ref_mem[i]) ref_mem[i] = '0;
    run_m = 1'b1;
  endtask

  task automatic set_a(input logic en, input logic we, input logic [13:0] ad,
                       input logic [63:0] wd, input logic [7:0] be);
    en_a = en; we_a = we; addr_a = ad; wd_a = wd; be_a = be;
  endtask

  task automatic set_b(input logic en, input logic we, input logic [13:0] ad,
                       input logic [63:0] wd, input logic [7:0] be);
    en_b = en; we_b = we; addr_b = ad; wd_b = wd; be_b = be;
  endtask

  initial begin
    rst_n = 1'b1;
    set_a(0, 0, '0, '0, '0);
    set_b(0, 0, '0, '0, '0);
    #2;
    reset_and_init();

    // Top address reads zero after fill.
    set_a(1, 0, 14'h3FFF, '0, '0);
    step();
    idle(NB_PIPE + 1);

    // Full write, single-byte overwrite, read back on port B.
    set_a(1, 1, 14'h0005, 64'h1122334455667788, 8'hFF);
    step();
    set_a(1, 1, 14'h0005, 64'h00000000000000AA, 8'h01);
    step();
    set_a(0, 0, '0, '0, '0);
    set_b(1, 0, 14'h0005, '0, '0);
    step();
    idle(NB_PIPE + 1);

    // Write/write collision with overlapping byte enables.
    set_a(1, 1, 14'h0010, 64'hFFFFFFFFFFFFFFFF, 8'h0F);
    set_b(1, 1, 14'h0010, 64'h0000000000000000, 8'hFF);
    step();
    set_b(0, 0, '0, '0, '0);
    set_a(1, 0, 14'h0010, '0, '0);
    step();
    idle(NB_PIPE + 1);

    // Read/write collision: old word 1, A writes 2, B reads.
    set_a(1, 1, 14'h0020, 64'h1, 8'hFF);
    step();
    set_a(1, 1, 14'h0020, 64'h2, 8'hFF);
    set_b(1, 0, 14'h0020, '0, '0);
    step();
    idle(NB_PIPE + 1);

    // Zero byte enable is a no-op.
    set_a(1, 1, 14'h0020, 64'hDEADBEEFDEADBEEF, 8'h00);
    step();
    set_a(1, 0, 14'h0020, '0, '0);
    step();
    idle(NB_PIPE + 1);

    // Streaming reads: fill 0..15, then A reads 0..7 while B reads 8..15.
    for (int i = 0; i < 8; i++) begin
      set_a(1, 1, 14'(i), {$urandom, $urandom}, 8'hFF);
      set_b(1, 1, 14'(i + 8), {$urandom, $urandom}, 8'hFF);
      step();
    end
    for (int i = 0; i < 8; i++) begin
      set_a(1, 0, 14'(i), '0, '0);
      set_b(1, 0, 14'(i + 8), '0, '0);
      step();
    end
    idle(NB_PIPE + 1);

    // Same stream interrupted by reset while reads are in flight.
    for (int i = 0; i < 5; i++) begin
      set_a(1, 0, 14'(i), '0, '0);
      set_b(1, 0, 14'(i + 8), '0, '0);
      step();
    end
    reset_and_init();
    idle(NB_PIPE + 2);

    // Random dual-port traffic over a small window to provoke collisions.
    for (int i = 0; i < 400; i++) begin
      set_a($urandom_range(0, 4) != 0, $urandom_range(0, 1) == 1, 14'($urandom_range(0, 31)),
            {$urandom, $urandom}, 8'($urandom));
      set_b($urandom_range(0, 4) != 0, $urandom_range(0, 1) == 1,
            ($urandom_range(0, 2) == 0) ? addr_a : 14'($urandom_range(0, 31)),
            {$urandom, $urandom}, 8'($urandom));
      step();
    end
    idle(NB_PIPE + 1);

    // Read back the whole random window.
    for (int i = 0; i < 16; i++) begin
      set_a(1, 0, 14'(2 * i), '0, '0);
      set_b(1, 0, 14'(2 * i + 1), '0, '0);
      step();
    end
    idle(NB_PIPE + 1);

    $display("%0d/%0d checks passed", pass_cnt, pass_cnt + fail_cnt);
    $finish;
  end

endmodule
